// File: rtl/thor2023_stlb_state_ctrl.sv
// STLB sequencer: reset walk, periodic LRU aging passes and invalidate-all sweeps
// that drive the downstream address/data staging stage.
package thor2023_stlb_pkg;
   typedef enum logic [3:0] {
      ST_RST     = 4'd0,
      ST_RUN     = 4'd1,
      ST_AGE1    = 4'd2,
      ST_AGE2    = 4'd3,
      ST_AGE3    = 4'd4,
      ST_AGE4    = 4'd5,
      ST_INVALL1 = 4'd6,
      ST_INVALL2 = 4'd7,
      ST_INVALL3 = 4'd8,
      ST_INVALL4 = 4'd9
   } tlb_state_t;
endpackage

module thor2023_stlb_state_ctrl
   import thor2023_stlb_pkg::*;
#(
   parameter int ENTRIES     = 1024,
   parameter int LOG_ENTRIES = $clog2(ENTRIES)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   lookup_active,
   input  logic                   age_tick,
   input  logic                   invall_req,
   output tlb_state_t             state,
   output logic [LOG_ENTRIES-1:0] rcount,
   output logic [LOG_ENTRIES-1:0] inv_count,
   output logic [5:0]             master_count,
   output logic                   busy,
   output logic                   invall_done
);

   localparam logic [LOG_ENTRIES-1:0] ROW_LAST = LOG_ENTRIES'(ENTRIES - 1);
   localparam logic [LOG_ENTRIES-1:0] ROW_ONE  = LOG_ENTRIES'(1);
   localparam logic [LOG_ENTRIES-1:0] ROW_ZERO = LOG_ENTRIES'(0);

   logic age_pend_r;
   logic inv_pend_r;

   // Sequencer FSM with registered indices, age stamp, busy and done pulse
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= ST_RST;
         rcount       <= ROW_ZERO;
         inv_count    <= ROW_ZERO;
         master_count <= 6'd0;
         busy         <= 1'b1;
         invall_done  <= 1'b0;
         age_pend_r   <= 1'b0;
         inv_pend_r   <= 1'b0;
      end else begin
         invall_done <= 1'b0;
         // Requests latch here; a sweep start below overrides with a clear
         if (age_tick) begin
            age_pend_r <= 1'b1;
         end else begin
            age_pend_r <= age_pend_r;
         end
         if (invall_req) begin
            inv_pend_r <= 1'b1;
         end else begin
            inv_pend_r <= inv_pend_r;
         end

         case (state)
            ST_RST: begin
               if (rcount == ROW_LAST) begin
                  state  <= ST_RUN;
                  rcount <= ROW_ZERO;
                  busy   <= 1'b0;
               end else begin
                  rcount <= rcount + ROW_ONE;
                  busy   <= 1'b1;
               end
            end
            ST_RUN: begin
               if (lookup_active) begin
                  busy <= 1'b0;
               end else if (inv_pend_r || invall_req) begin
                  state      <= ST_INVALL1;
                  busy       <= 1'b1;
                  inv_pend_r <= 1'b0;
               end else if (age_pend_r || age_tick) begin
                  state      <= ST_AGE1;
                  busy       <= 1'b1;
                  age_pend_r <= 1'b0;
               end else begin
                  busy <= 1'b0;
               end
            end
            ST_AGE1: state <= ST_AGE2;
            ST_AGE2: state <= ST_AGE3;
            ST_AGE3: state <= ST_AGE4;
            ST_AGE4: begin
               if (rcount == ROW_LAST) begin
                  state        <= ST_RUN;
                  rcount       <= ROW_ZERO;
                  busy         <= 1'b0;
                  master_count <= (master_count == 6'd63) ? 6'd63 : master_count + 6'd1;
               end else begin
                  state  <= ST_AGE1;
                  rcount <= rcount + ROW_ONE;
               end
            end
            ST_INVALL1: state <= ST_INVALL2;
            ST_INVALL2: state <= ST_INVALL3;
            ST_INVALL3: state <= ST_INVALL4;
            ST_INVALL4: begin
               if (inv_count == ROW_LAST) begin
                  state        <= ST_RUN;
                  inv_count    <= ROW_ZERO;
                  master_count <= 6'd0;
                  invall_done  <= 1'b1;
                  busy         <= 1'b0;
               end else begin
                  state     <= ST_INVALL1;
                  inv_count <= inv_count + ROW_ONE;
               end
            end
            default: begin
               state     <= ST_RUN;
               rcount    <= ROW_ZERO;
               inv_count <= ROW_ZERO;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_thor2023_stlb_state_ctrl.sv
// Directed self-checking bench for thor2023_stlb_state_ctrl with ENTRIES=16.
module tb_thor2023_stlb_state_ctrl;
   import thor2023_stlb_pkg::*;

   localparam int ENTRIES = 16;
   localparam int LOGE    = 4;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            lookup_active = 1'b0;
   logic            age_tick = 1'b0;
   logic            invall_req = 1'b0;
   tlb_state_t      state;
   logic [LOGE-1:0] rcount;
   logic [LOGE-1:0] inv_count;
   logic [5:0]      master_count;
   logic            busy;
   logic            invall_done;

   int checks = 0;
   int errors = 0;

   tlb_state_t age_seq [4] = '{ST_AGE1, ST_AGE2, ST_AGE3, ST_AGE4};
   tlb_state_t inv_seq [4] = '{ST_INVALL1, ST_INVALL2, ST_INVALL3, ST_INVALL4};

   thor2023_stlb_state_ctrl #(.ENTRIES(ENTRIES)) dut (
      .clk          (clk),
      .rst          (rst),
      .lookup_active(lookup_active),
      .age_tick     (age_tick),
      .invall_req   (invall_req),
      .state        (state),
      .rcount       (rcount),
      .inv_count    (inv_count),
      .master_count (master_count),
      .busy         (busy),
      .invall_done  (invall_done)
   );

   always #5 clk = ~clk;

   // Stimulus helper: reset pulse followed by the complete 16-cycle walk
   task automatic apply_reset();
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (ENTRIES) @(negedge clk);
   endtask

   // Stimulus helper: one aging pass, bounded wait for the return to ST_RUN
   task automatic do_age_pass();
      int n;
      age_tick = 1'b1;
      @(negedge clk);
      age_tick = 1'b0;
      n = 0;
      while (state != ST_RUN && n < 4 * ENTRIES + 8) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (state !== ST_RUN) begin
         errors++;
         $display("FAIL age_pass_timeout: state=%0d required=%0d", state, ST_RUN);
      end
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      checks++;
      if (state !== ST_RST || rcount !== 4'd0 || inv_count !== 4'd0 ||
          master_count !== 6'd0 || busy !== 1'b1 || invall_done !== 1'b0) begin
         errors++;
         $display("FAIL reset_values: state=%0d rc=%0d ic=%0d mc=%0d busy=%b done=%b required 0/0/0/0/1/0",
                  state, rcount, inv_count, master_count, busy, invall_done);
      end
      rst = 1'b1;
      for (int i = 0; i < ENTRIES; i++) begin
         checks++;
         if (state !== ST_RST || rcount !== 4'(i) || busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_walk[%0d]: state=%0d rc=%0d busy=%b required state=%0d rc=%0d busy=1",
                     i, state, rcount, busy, ST_RST, i);
         end
         @(negedge clk);
      end
      checks++;
      if (state !== ST_RUN || rcount !== 4'd0 || busy !== 1'b0 || master_count !== 6'd0) begin
         errors++;
         $display("FAIL reset_to_run: state=%0d rc=%0d busy=%b mc=%0d required %0d/0/0/0",
                  state, rcount, busy, master_count, ST_RUN);
      end
   endtask

   task automatic test_age_sweep();
      age_tick = 1'b1;
      @(negedge clk);
      age_tick = 1'b0;
      for (int r = 0; r < ENTRIES; r++) begin
         for (int s = 0; s < 4; s++) begin
            checks++;
            if (state !== age_seq[s] || rcount !== 4'(r) || busy !== 1'b1) begin
               errors++;
               $display("FAIL age_seq[%0d.%0d]: state=%0d rc=%0d busy=%b required state=%0d rc=%0d busy=1",
                        r, s, state, rcount, busy, age_seq[s], r);
            end
            @(negedge clk);
         end
      end
      checks++;
      if (state !== ST_RUN || busy !== 1'b0 || master_count !== 6'd1 || rcount !== 4'd0) begin
         errors++;
         $display("FAIL age_end: state=%0d busy=%b mc=%0d rc=%0d required %0d/0/1/0",
                  state, busy, master_count, rcount, ST_RUN);
      end
   endtask

   task automatic test_age_saturate();
      int exp_mc;
      for (int k = 2; k <= 71; k++) begin
         do_age_pass();
         exp_mc = (k > 63) ? 63 : k;
         checks++;
         if (master_count !== 6'(exp_mc)) begin
            errors++;
            $display("FAIL age_saturate[%0d]: mc=%0d required %0d", k, master_count, exp_mc);
         end
      end
   endtask

   task automatic test_invall();
      apply_reset();
      repeat (3) do_age_pass();
      checks++;
      if (master_count !== 6'd3) begin
         errors++;
         $display("FAIL invall_pre_mc: mc=%0d required 3", master_count);
      end
      invall_req = 1'b1;
      @(negedge clk);
      invall_req = 1'b0;
      for (int r = 0; r < ENTRIES; r++) begin
         for (int s = 0; s < 4; s++) begin
            checks++;
            if (state !== inv_seq[s] || inv_count !== 4'(r) || busy !== 1'b1 ||
                rcount !== 4'd0 || invall_done !== 1'b0) begin
               errors++;
               $display("FAIL invall_seq[%0d.%0d]: state=%0d ic=%0d rc=%0d busy=%b done=%b required state=%0d ic=%0d rc=0 busy=1 done=0",
                        r, s, state, inv_count, rcount, busy, invall_done, inv_seq[s], r);
            end
            @(negedge clk);
         end
      end
      checks++;
      if (state !== ST_RUN || invall_done !== 1'b1 || master_count !== 6'd0 ||
          inv_count !== 4'd0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL invall_done_cycle: state=%0d done=%b mc=%0d ic=%0d busy=%b required %0d/1/0/0/0",
                  state, invall_done, master_count, inv_count, busy, ST_RUN);
      end
      @(negedge clk);
      checks++;
      if (invall_done !== 1'b0 || state !== ST_RUN) begin
         errors++;
         $display("FAIL invall_done_single: done=%b state=%0d required 0/%0d", invall_done, state, ST_RUN);
      end
   endtask

   task automatic test_both_requests();
      age_tick   = 1'b1;
      invall_req = 1'b1;
      @(negedge clk);
      age_tick   = 1'b0;
      invall_req = 1'b0;
      checks++;
      if (state !== ST_INVALL1) begin
         errors++;
         $display("FAIL both_priority: state=%0d required %0d", state, ST_INVALL1);
      end
      repeat (4 * ENTRIES) @(negedge clk);
      checks++;
      if (state !== ST_RUN || invall_done !== 1'b1 || master_count !== 6'd0) begin
         errors++;
         $display("FAIL both_invall_end: state=%0d done=%b mc=%0d required %0d/1/0",
                  state, invall_done, master_count, ST_RUN);
      end
      @(negedge clk);
      checks++;
      if (state !== ST_AGE1 || rcount !== 4'd0 || invall_done !== 1'b0) begin
         errors++;
         $display("FAIL both_age_start: state=%0d rc=%0d done=%b required %0d/0/0",
                  state, rcount, invall_done, ST_AGE1);
      end
      repeat (4 * ENTRIES) @(negedge clk);
      checks++;
      if (state !== ST_RUN || master_count !== 6'd1) begin
         errors++;
         $display("FAIL both_age_end: state=%0d mc=%0d required %0d/1", state, master_count, ST_RUN);
      end
   endtask

   task automatic test_lookup_block();
      for (int c = 0; c < 10; c++) begin
         lookup_active = 1'b1;
         age_tick      = (c == 2) ? 1'b1 : 1'b0;
         @(negedge clk);
         checks++;
         if (state !== ST_RUN || busy !== 1'b0) begin
            errors++;
            $display("FAIL lookup_hold[%0d]: state=%0d busy=%b required %0d/0", c, state, busy, ST_RUN);
         end
      end
      lookup_active = 1'b0;
      age_tick      = 1'b0;
      @(negedge clk);
      checks++;
      if (state !== ST_AGE1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL lookup_release: state=%0d busy=%b required %0d/1", state, busy, ST_AGE1);
      end
      repeat (4 * ENTRIES) @(negedge clk);
      checks++;
      if (state !== ST_RUN || master_count !== 6'd2) begin
         errors++;
         $display("FAIL lookup_age_end: state=%0d mc=%0d required %0d/2", state, master_count, ST_RUN);
      end
   endtask

   task automatic test_reset_mid_sweep();
      age_tick = 1'b1;
      @(negedge clk);
      age_tick = 1'b0;
      for (int c = 0; c < 7 * 4 + 2; c++) begin
         invall_req = (c == 5) ? 1'b1 : 1'b0;
         @(negedge clk);
      end
      invall_req = 1'b0;
      checks++;
      if (state !== ST_AGE3 || rcount !== 4'd7) begin
         errors++;
         $display("FAIL mid_sweep_position: state=%0d rc=%0d required %0d/7", state, rcount, ST_AGE3);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (state !== ST_RST || rcount !== 4'd0 || inv_count !== 4'd0 ||
          master_count !== 6'd0 || busy !== 1'b1 || invall_done !== 1'b0) begin
         errors++;
         $display("FAIL mid_sweep_async_reset: state=%0d rc=%0d ic=%0d mc=%0d busy=%b done=%b required 0/0/0/0/1/0",
                  state, rcount, inv_count, master_count, busy, invall_done);
      end
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < ENTRIES; i++) begin
         checks++;
         if (state !== ST_RST || rcount !== 4'(i)) begin
            errors++;
            $display("FAIL mid_reset_walk[%0d]: state=%0d rc=%0d required %0d/%0d", i, state, rcount, ST_RST, i);
         end
         @(negedge clk);
      end
      for (int c = 0; c < 20; c++) begin
         checks++;
         if (state !== ST_RUN || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_no_pending[%0d]: state=%0d busy=%b required %0d/0", c, state, busy, ST_RUN);
         end
         @(negedge clk);
      end
   endtask

   initial begin
      test_reset();
      test_age_sweep();
      test_age_saturate();
      test_invall();
      test_both_requests();
      test_lookup_block();
      test_reset_mid_sweep();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
